// File: rtl/mul16_pkg.sv
// Shared types and sizes for the 16x16 shift-add multiplier.
package mul16_pkg;

    localparam int WIDTH  = 16;
    localparam int STEPS  = 16;
    localparam int STEP_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mul16_seq_add16.sv
// Plain 16-bit adder used by the multiplier accumulation step; no carry-out port.
module add16
    import mul16_pkg::*;
(
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] sum
);

    assign sum = in1 + in2;

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-add multiplier, one partial product per cycle.
// Optional MUL16_ZERO_SKIP_EN: zero operands bypass RUN and complete immediately.
module mul16_seq
    import mul16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [STEP_W-1:0]  step;
    logic [WIDTH-1:0]   add_in2;
    logic [WIDTH-1:0]   add_sum;
    logic               carry;
    logic               accept;

    assign add_in2 = lo[0] ? mcand : '0;

    add16 u_add (
        .in1 (hi),
        .in2 (add_in2),
        .sum (add_sum)
    );

    // Carry-out recovered from the operand and sum MSBs.
    assign carry = (hi[WIDTH-1] & add_in2[WIDTH-1]) |
                   ((hi[WIDTH-1] ^ add_in2[WIDTH-1]) & ~add_sum[WIDTH-1]);

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            step  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= a;
                        hi    <= '0;
                        step  <= '0;
`ifdef MUL16_ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            lo    <= '0;
                            state <= DONE;
                        end else begin
                            lo    <= b;
                            state <= RUN;
                        end
`else
                        lo    <= b;
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    hi   <= {carry, add_sum[WIDTH-1:1]};
                    lo   <= {add_sum[0], lo[WIDTH-1:1]};
                    step <= step + 1'b1;
                    if (step == STEP_W'(STEPS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced inactive for as long as rst is held.
    assign in_ready  = (state == IDLE) && !rst;
    assign res_valid = (state == DONE) && !rst;
    assign busy      = ((state == RUN) || (state == DONE)) && !rst;
    assign product   = res_valid ? {hi, lo} : '0;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed vector bench for mul16_seq: products, latency, backpressure, reset abort.
module tb_mul16_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] product;
    logic        busy;

    int n_cmp;
    int n_err;

`ifdef MUL16_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 17;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    mul16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one operation; lat counts the accept edge as edge 1.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] exp, input int exp_lat,
                          input bit noise, input string nm);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({nm, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a = '0;
        b = '0;
        if (exp_lat > 1) check({nm, " busy in RUN"}, {31'd0, busy}, 32'd1);
        while (!res_valid && lat < 40) begin
            if (noise) begin
                in_valid = lat[0];
                a = 16'h7777;
                b = 16'h7777;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " product"}, product, exp);
        check({nm, " busy in DONE"}, {31'd0, busy}, 32'd1);
        if (res_ready) begin
            @(posedge clk);
            @(negedge clk);
            check({nm, " in_ready after"}, {31'd0, in_ready}, 32'd1);
            check({nm, " product cleared"}, product, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] held;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        res_ready = 1'b1;

        vecs[0] = '{16'd3,     16'd5,     32'h0000000F, 17};
        vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001, 17};
        vecs[2] = '{16'd100,   16'd69,    32'd6900,     17};
        vecs[3] = '{16'h0000,  16'h1234,  32'd0,        ZLAT};
        vecs[4] = '{16'hABCD,  16'h0000,  32'd0,        ZLAT};
        vecs[5] = '{16'd1,     16'd1,     32'd1,        17};
        vecs[6] = '{16'hFFFF,  16'd1,     32'h0000FFFF, 17};
        vecs[7] = '{16'h8000,  16'd2,     32'h00010000, 17};
        vecs[8] = '{16'h1234,  16'h5678,  32'h06260060, 17};
        vecs[9] = '{16'hFFFF,  16'h8000,  32'h7FFF8000, 17};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst in_ready",  {31'd0, in_ready},  32'd0);
        check("rst res_valid", {31'd0, res_valid}, 32'd0);
        check("rst busy",      {31'd0, busy},      32'd0);
        check("rst product",   product,            32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after rst", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
        end

        // in_valid noise during RUN must not disturb the accepted operands
        run_op(16'd11, 16'd13, 32'd143, 17, 1'b1, "noise");

        // Backpressure: result held for 5 cycles, then released
        res_ready = 1'b0;
        run_op(16'd250, 16'd4, 32'd1000, 17, 1'b0, "hold");
        held = product;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold res_valid", {31'd0, res_valid}, 32'd1);
            check("hold product", product, 32'd1000);
        end
        check("hold in_ready", {31'd0, in_ready}, 32'd0);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release in_ready", {31'd0, in_ready}, 32'd1);
        check("release res_valid", {31'd0, res_valid}, 32'd0);

        // Reset while a result is waiting in DONE
        res_ready = 1'b0;
        run_op(16'd9, 16'd9, 32'd81, 17, 1'b0, "done_rst");
        rst = 1'b1;
        #1;
        check("done_rst product", product, 32'd0);
        check("done_rst res_valid", {31'd0, res_valid}, 32'd0);
        check("done_rst busy", {31'd0, busy}, 32'd0);
        check("done_rst in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        #1;
        check("done_rst in_ready after", {31'd0, in_ready}, 32'd1);
        check("done_rst no result", {31'd0, res_valid}, 32'd0);
        @(negedge clk);

        // Reset in the middle of RUN aborts the operation
        a = 16'd7;
        b = 16'd9;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("abort busy mid-run", {31'd0, busy}, 32'd1);
        check("abort no early valid", {31'd0, res_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort busy in rst", {31'd0, busy}, 32'd0);
        check("abort in_ready in rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort in_ready after", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) check("abort spurious valid", 32'd1, 32'd0);
        end
        check("abort idle", {31'd0, in_ready}, 32'd1);
        run_op(16'd2, 16'd2, 32'd4, 17, 1'b0, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits and product width at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  16  multiplicand, unsigned.
REQ-007 b  input  16  multiplier, unsigned.
REQ-008 res_valid  output  1  product is valid.
REQ-009 res_ready  input  1  consumer accepts the product.
REQ-010 product  output  32  unsigned a*b.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 The state machine SHALL have three states: IDLE, RUN, DONE.
REQ-013 in_ready SHALL be high only in IDLE with rst low; res_valid SHALL be high only in DONE.
REQ-014 Accept = in_valid && in_ready; on accept: mcand<=a, lo<=b, hi<=0, step<=0, next state RUN.
REQ-015 in_valid while not in IDLE SHALL be ignored; a and b SHALL be sampled only on the accept edge.
REQ-016 Each RUN cycle: if lo[0], {c,hi'} = hi + mcand (17-bit result), else {c,hi'} = {0,hi}; then {hi,lo} <= {c,hi',lo} >> 1; step increments.
REQ-017 The carry c SHALL be derived from the 16-bit adder as (x15&y15) | ((x15^y15) & ~sum15), because the adder has no carry-out port.
REQ-018 After exactly 16 RUN cycles (step==15 on its final update), the next state SHALL be DONE.
REQ-019 Latency: res_valid SHALL rise 17 clk edges after the accept edge.
REQ-020 product SHALL equal {hi,lo} in DONE and remain stable while res_valid && !res_ready.
REQ-021 On res_valid && res_ready, the next state SHALL be IDLE; a new accept is not possible in that same cycle.
REQ-022 Overflow cannot occur; 0xFFFF*0xFFFF = 0xFFFE0001 SHALL be exact.
REQ-023 product SHALL read 0 whenever the state is not DONE.

Reset
REQ-024 With rst high at an edge: state<=IDLE, and hi, lo, mcand and step <= 0.
REQ-025 While rst is high: in_ready=0, res_valid=0, busy=0, product=0.
REQ-026 rst in RUN or DONE SHALL abort the operation with no result delivered; in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-027 Macro MUL16_ZERO_SKIP_EN: when defined, an accept with a==0 or b==0 SHALL go directly IDLE->DONE with product 0 (res_valid 1 edge after accept).
REQ-028 Without MUL16_ZERO_SKIP_EN: zero operands SHALL take the full 16-step path (17-edge latency).

Structure
REQ-029 Package mul16_pkg SHALL hold the state enum (IDLE, RUN, DONE), WIDTH=16, and STEPS=16.
REQ-030 The accumulation add SHALL instantiate the existing add16 sub-module (in1=hi, in2=mcand or 0); no other sub-module.

Verification
REQ-031 a=3, b=5, res_ready=1 -> product 0x0000000F, res_valid exactly 17 edges after accept, in_ready 1 the cycle after.
REQ-032 a=0xFFFF, b=0xFFFF -> product 0xFFFE0001; a=100, b=69 -> product 6900 (0x1AF4).
REQ-033 res_ready held 0 for 5 cycles in DONE -> product and res_valid stable; IDLE entered the edge after res_ready rises.
REQ-034 a=0, b=0x1234 -> product 0; latency 1 edge with MUL16_ZERO_SKIP_EN defined, 17 edges without it.
REQ-035 rst pulsed at RUN step 8 -> no res_valid; in_ready=1 the cycle after rst; a following 2*2 -> product 4.
REQ-036 in_valid toggled with new a/b during RUN -> ignored; result reflects the originally accepted operands.
